bitcoin_msg_loader: RTL and testbench

BITCOIN_MSG_LOADER -- requirements
Module: bitcoin_msg_loader

---
 rtl/bitcoin_msg_loader_if.sv | 27 ++
 rtl/bitcoin_msg_loader.sv | 199 +++++++++++++++++++
 tb/tb_bitcoin_msg_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bitcoin_msg_loader_if.sv
// Stream/memory bus of bitcoin_msg_loader: header memory read port plus the
// valid/ready message-word output toward the hashing core.
interface bitcoin_msg_loader_if;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_read_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_widx;
  logic [4:0]  out_blk;
  logic        out_last;

  modport master (
    output mem_addr, mem_we,
    input  mem_read_data,
    output out_valid, out_data, out_widx, out_blk, out_last,
    input  out_ready
  );

  modport slave (
    input  mem_addr, mem_we,
    output mem_read_data,
    input  out_valid, out_data, out_widx, out_blk, out_last,
    output out_ready
  );
endinterface

// File: rtl/bitcoin_msg_loader.sv
// Fetches the 19-word block header and streams the header block followed by
// NUM_NONCES padded nonce blocks. Optional macro MSG_LOADER_BSWAP_EN byte-reverses captured header words.
module bitcoin_msg_loader #(
  parameter int NUM_NONCES = 16,
  parameter int HDR_WORDS  = 19
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  output logic        busy,
  output logic        done,
  bitcoin_msg_loader_if.master bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    EMIT_HDR   = 3'd2,
    EMIT_NONCE = 3'd3,
    FIN        = 3'd4
  } state_t;

  localparam logic [4:0] LAST_BLK  = 5'(NUM_NONCES);
  localparam logic [4:0] FETCH_END = 5'(HDR_WORDS);

  state_t      state_r, next_state_s;
  logic [4:0]  fetch_cnt_r, next_fetch_s;
  logic [15:0] base_r, next_base_s;
  logic [15:0] mem_addr_r, next_addr_s;
  logic        out_valid_r, next_valid_s;
  logic [31:0] out_data_r, next_data_s;
  logic [3:0]  out_widx_r, next_widx_s;
  logic [4:0]  out_blk_r, next_blk_s;
  logic        out_last_r, next_last_s;
  logic        busy_r, done_r;
  logic [31:0] cap_word_s;
  logic [31:0] hdr_r [0:HDR_WORDS-1];

`ifdef MSG_LOADER_BSWAP_EN
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign cap_word_s = bswap32(bus.mem_read_data);
`else
  assign cap_word_s = bus.mem_read_data;
`endif

  // Word w of block blk: block 0 is the header, block n+1 carries nonce n.
  function automatic logic [31:0] msg_word(input logic [4:0] blk, input logic [3:0] widx);
    logic [31:0] w;
    w = 32'd0;
    if (blk == 5'd0) begin
      w = hdr_r[{1'b0, widx}];
    end else begin
      case (widx)
        4'd0, 4'd1, 4'd2: w = hdr_r[5'd16 + {1'b0, widx}];
        4'd3:             w = {27'd0, blk - 5'd1};
        4'd4:             w = 32'h8000_0000;
        4'd15:            w = 32'd640;
        default:          w = 32'd0;
      endcase
    end
    return w;
  endfunction

  // Next-state and next-output decode.
  always_comb begin
    next_state_s = state_r;
    next_fetch_s = fetch_cnt_r;
    next_base_s  = base_r;
    next_addr_s  = mem_addr_r;
    next_valid_s = out_valid_r;
    next_data_s  = out_data_r;
    next_widx_s  = out_widx_r;
    next_blk_s   = out_blk_r;
    next_last_s  = out_last_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = FETCH;
          next_fetch_s = 5'd0;
          next_base_s  = message_addr;
          next_addr_s  = message_addr;
        end else begin
          next_state_s = IDLE;
        end
      end
      FETCH: begin
        // Read data trails the address by one cycle, so the last capture lands at count HDR_WORDS.
        if (fetch_cnt_r == FETCH_END) begin
          next_state_s = EMIT_HDR;
          next_fetch_s = 5'd0;
          next_addr_s  = 16'd0;
          next_valid_s = 1'b1;
          next_data_s  = msg_word(5'd0, 4'd0);
          next_widx_s  = 4'd0;
          next_blk_s   = 5'd0;
          next_last_s  = 1'b0;
        end else begin
          next_fetch_s = fetch_cnt_r + 5'd1;
          if (fetch_cnt_r < FETCH_END - 5'd1) begin
            next_addr_s = base_r + {11'd0, fetch_cnt_r + 5'd1};
          end else begin
            next_addr_s = 16'd0;
          end
        end
      end
      EMIT_HDR, EMIT_NONCE: begin
        if (out_valid_r && bus.out_ready) begin
          if (out_widx_r == 4'd15) begin
            if (out_blk_r == LAST_BLK) begin
              next_state_s = FIN;
              next_valid_s = 1'b0;
              next_data_s  = 32'd0;
              next_widx_s  = 4'd0;
              next_blk_s   = 5'd0;
              next_last_s  = 1'b0;
            end else begin
              next_state_s = EMIT_NONCE;
              next_blk_s   = out_blk_r + 5'd1;
              next_widx_s  = 4'd0;
              next_data_s  = msg_word(out_blk_r + 5'd1, 4'd0);
              next_last_s  = 1'b0;
            end
          end else begin
            next_widx_s = out_widx_r + 4'd1;
            next_data_s = msg_word(out_blk_r, out_widx_r + 4'd1);
            next_last_s = (out_widx_r == 4'd14);
          end
        end else begin
          next_state_s = state_r;
        end
      end
      FIN: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
        next_valid_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt_r <= 5'd0;
      base_r      <= 16'd0;
      mem_addr_r  <= 16'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 32'd0;
      out_widx_r  <= 4'd0;
      out_blk_r   <= 5'd0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      fetch_cnt_r <= next_fetch_s;
      base_r      <= next_base_s;
      mem_addr_r  <= next_addr_s;
      out_valid_r <= next_valid_s;
      out_data_r  <= next_data_s;
      out_widx_r  <= next_widx_s;
      out_blk_r   <= next_blk_s;
      out_last_r  <= next_last_s;
      busy_r      <= (next_state_s != IDLE);
      done_r      <= (next_state_s == FIN);
    end
  end

  // Header capture; storage content is don't-care after reset.
  always_ff @(posedge clk) begin
    if (state_r == FETCH && fetch_cnt_r != 5'd0) begin
      hdr_r[fetch_cnt_r - 5'd1] <= cap_word_s;
    end
  end

  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_we    = 1'b0;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_widx  = out_widx_r;
  assign bus.out_blk   = out_blk_r;
  assign bus.out_last  = out_last_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_bitcoin_msg_loader.sv
// Randomised bench for bitcoin_msg_loader: memory model, transfer-order model
// built from the message-format rules, and a per-cycle stream checker.
module tb_bitcoin_msg_loader;
  localparam int NN   = 16;
  localparam int NXF  = 16 * (NN + 1);

  typedef struct {
    logic [31:0] d;
    logic [3:0]  w;
    logic [4:0]  b;
    logic        l;
  } xfer_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] message_addr = 16'd0;
  logic        busy, done;
  bitcoin_msg_loader_if bus();

  int          checks = 0;
  int          errors = 0;
  int          bp_pct = 0;
  int          mem_mode = 0;
  logic [15:0] dir_base = 16'h0040;
  logic [31:0] seed = 32'd0;
  int          xfer_cnt = 0;
  xfer_t       exp_q[$];
  logic [31:0] exp_d [0:NXF-1];
  logic [31:0] log_d [0:NXF-1];
  logic [4:0]  log_b [0:NXF-1];
  logic        log_l [0:NXF-1];

  bitcoin_msg_loader #(.NUM_NONCES(NN), .HDR_WORDS(19)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .message_addr(message_addr),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [15:0] a);
    logic [15:0] off;
    off = a - dir_base;
    if (mem_mode == 0) return 32'h1000_0000 + {16'd0, off};
    return seed ^ ({16'd0, a} * 32'h9E37_79B1) ^ {a, ~a};
  endfunction

  function automatic logic [31:0] hdr_store(input logic [31:0] x);
`ifdef MSG_LOADER_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Memory: data for the address seen at a clock edge appears after that edge.
  initial begin
    bus.mem_read_data = 32'd0;
    forever begin
      @(posedge clk);
      bus.mem_read_data <= memf(bus.mem_addr);
    end
  end

  // Consumer backpressure.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = ($urandom_range(99) >= bp_pct);
    end
  end

  // Stream checker: every accepted word against the model, every stall for stability.
  initial begin
    xfer_t e;
    xfer_t p;
    logic  prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        chk("mem_we", {31'd0, bus.mem_we}, 32'd0);
        if (prev_stall) begin
          chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
          chk("stall_data", bus.out_data, p.d);
          chk("stall_widx", {28'd0, bus.out_widx}, {28'd0, p.w});
          chk("stall_blk", {27'd0, bus.out_blk}, {27'd0, p.b});
          chk("stall_last", {31'd0, bus.out_last}, {31'd0, p.l});
        end
        if (bus.out_valid) begin
          chk("valid_busy", {31'd0, busy}, 32'd1);
          if (bus.out_ready) begin
            if (exp_q.size() == 0) begin
              chk("xfer_extra", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("xfer_data", bus.out_data, e.d);
              chk("xfer_widx", {28'd0, bus.out_widx}, {28'd0, e.w});
              chk("xfer_blk", {27'd0, bus.out_blk}, {27'd0, e.b});
              chk("xfer_last", {31'd0, bus.out_last}, {31'd0, e.l});
            end
            if (xfer_cnt < NXF) begin
              log_d[xfer_cnt] = bus.out_data;
              log_b[xfer_cnt] = bus.out_blk;
              log_l[xfer_cnt] = bus.out_last;
            end
            xfer_cnt++;
          end
          prev_stall = !bus.out_ready;
          p.d = bus.out_data; p.w = bus.out_widx; p.b = bus.out_blk; p.l = bus.out_last;
        end else begin
          prev_stall = 1'b0;
        end
      end
    end
  end

  // Expected transfer order for one run, derived from the message format.
  task automatic build_model(input logic [15:0] base);
    logic [31:0] h [0:18];
    logic [31:0] d;
    xfer_t x;
    exp_q.delete();
    for (int i = 0; i < 19; i++) h[i] = hdr_store(memf(base + 16'(i)));
    for (int b = 0; b <= NN; b++) begin
      for (int w = 0; w < 16; w++) begin
        if (b == 0)       d = h[w];
        else if (w < 3)   d = h[16 + w];
        else if (w == 3)  d = 32'(b - 1);
        else if (w == 4)  d = 32'h8000_0000;
        else if (w == 15) d = 32'd640;
        else              d = 32'd0;
        x.d = d; x.w = 4'(w); x.b = 5'(b); x.l = (w == 15);
        exp_d[b * 16 + w] = d;
        exp_q.push_back(x);
      end
    end
  endtask

  task automatic run(input logic [15:0] base, input int bp, input int abort_blk);
    bit seen_done;
    build_model(base);
    bp_pct = bp;
    xfer_cnt = 0;
    @(posedge clk); #2;
    message_addr = base;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      chk("fetch_addr", {16'd0, bus.mem_addr}, {16'd0, base + 16'(k)});
      chk("fetch_busy", {31'd0, busy}, 32'd1);
      start = (k == 10);
    end
    start = 1'b0;
    @(negedge clk);
    chk("fetch19_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("hdr_first_valid", {31'd0, bus.out_valid}, 32'd1);
    seen_done = 1'b0;
    for (int c = 0; c < 4000 && !seen_done; c++) begin
      if (abort_blk > 0 && bus.out_valid && bus.out_blk == 5'(abort_blk)) begin
        #1 reset_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data", bus.out_data, 32'd0);
        chk("rst_blk", {27'd0, bus.out_blk}, 32'd0);
        chk("rst_addr", {16'd0, bus.mem_addr}, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        exp_q.delete();
        repeat (5) @(negedge clk);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        return;
      end
      if (done) seen_done = 1'b1;
      else @(negedge clk);
    end
    chk("done_seen", {31'd0, seen_done}, 32'd1);
    chk("fin_busy", {31'd0, busy}, 32'd1);
    chk("xfer_count", 32'(xfer_cnt), 32'(NXF));
    chk("model_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk("reset_widx", {28'd0, bus.out_widx}, 32'd0);
    reset_n = 1'b1;

    mem_mode = 0;
    dir_base = 16'h0040;
    run(16'h0040, 0, 0);
`ifndef MSG_LOADER_BSWAP_EN
    chk("pin_model_w0", exp_d[0], 32'h1000_0000);
    chk("pin_model_w15", exp_d[15], 32'h1000_000F);
    chk("pin_dut_w0", log_d[0], 32'h1000_0000);
    chk("pin_dut_w15", log_d[15], 32'h1000_000F);
    chk("pin_n5_w0", log_d[96], 32'h1000_0010);
    chk("pin_n5_w2", log_d[98], 32'h1000_0012);
`else
    chk("pin_bswap_w0", log_d[0], 32'h0000_0010);
    chk("pin_bswap_n0w1", log_d[17], 32'h1100_0010);
`endif
    chk("pin_n5_w3", log_d[99], 32'h0000_0005);
    chk("pin_n5_w4", log_d[100], 32'h8000_0000);
    chk("pin_n5_w9", log_d[105], 32'h0000_0000);
    chk("pin_n5_w15", log_d[111], 32'h0000_0280);
    chk("pin_n5_blk", {27'd0, log_b[96]}, 32'd6);
    chk("pin_n5_last14", {31'd0, log_l[110]}, 32'd0);
    chk("pin_n5_last15", {31'd0, log_l[111]}, 32'd1);

    run(16'h0040, 30, 0);

    mem_mode = 1;
    seed = $urandom;
    run(16'hFFF8, 30, 0);

    seed = $urandom;
    run(16'($urandom), 20, 4);
    seed = $urandom;
    run(16'($urandom), 30, 0);
    for (int r = 0; r < 2; r++) begin
      seed = $urandom;
      run(16'($urandom), $urandom_range(50), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
